// File: rtl/multicycle_control_if.sv
// Control-unit port bundle: decode inputs and memory handshake in, datapath controls out.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_if #(
   parameter int unsigned ALU_CTRL_W = 3
);
   logic [5:0]            op;
   logic [5:0]            funct;
   logic                  mem_ready;
   logic                  pc_write;
   logic                  pc_write_cond;
   logic                  ir_write;
   logic                  reg_write;
   logic                  mem_read;
   logic                  mem_write;
   logic                  i_or_d;
   logic                  mem_to_reg;
   logic                  reg_dst;
   logic                  alu_src_a;
   logic [1:0]            alu_src_b;
   logic [1:0]            pc_source;
   logic [ALU_CTRL_W-1:0] alu_ctrl;
   logic                  retire;
   logic                  illegal;
   logic                  bus_err;
   logic [3:0]            state_out;

   modport master (
      input  op, funct, mem_ready,
      output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
      output i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source,
      output alu_ctrl, retire, illegal, bus_err, state_out
   );

   modport slave (
      output op, funct, mem_ready,
      input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
      input  i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source,
      input  alu_ctrl, retire, illegal, bus_err, state_out
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing with a
// memory-ready timeout and sticky illegal/bus-error trap.
module multicycle_control #(
   parameter int unsigned ALU_CTRL_W  = 3,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input logic                  clk,
   input logic                  rst_n,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StRWb      = 4'd7,
      StExecI    = 4'd8,
      StIWb      = 4'd9,
      StBranch   = 4'd10,
      StJump     = 4'd11,
      StTrap     = 4'd12
   } state_e;

   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpJ    = 6'b000010;

   localparam logic [2:0] AluAdd = 3'b001;
   localparam logic [2:0] AluSub = 3'b010;
   localparam logic [2:0] AluAnd = 3'b011;
   localparam logic [2:0] AluOr  = 3'b100;
   localparam logic [2:0] AluSlt = 3'b101;

   localparam int unsigned     CntW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            illegal_q, illegal_d;
   logic            bus_err_q, bus_err_d;
   logic            is_store_q, is_store_d;
   logic            r_legal;
   logic [2:0]      r_alu;
   logic            waiting;
   logic            timeout;

   always_comb begin
      r_legal = 1'b1;
      r_alu   = AluAdd;
      case (bus.funct)
         6'b100000: r_alu = AluAdd;
         6'b100010: r_alu = AluSub;
         6'b100100: r_alu = AluAnd;
         6'b100101: r_alu = AluOr;
         6'b101010: r_alu = AluSlt;
         default:   r_legal = 1'b0;
      endcase
   end

   assign waiting = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
   // A ready on the final allowed cycle beats the timeout.
   assign timeout = (MEM_TIMEOUT != 0) && waiting && !bus.mem_ready && (wait_cnt_q == CntLast);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StFetch;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
         is_store_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
         is_store_q <= is_store_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      is_store_d = is_store_q;
      case (state_q)
         StFetch: begin
            if (bus.mem_ready) begin
               state_d = StDecode;
            end else if (timeout) begin
               state_d   = StTrap;
               bus_err_d = 1'b1;
            end
         end
         StDecode: begin
            // Latch lw/sw here so op is not needed again in MEM_ADDR.
            is_store_d = (bus.op == OpSw);
            case (bus.op)
               OpLw, OpSw: state_d = StMemAddr;
               OpAddi:     state_d = StExecI;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpR: begin
                  if (r_legal) begin
                     state_d = StExecR;
                  end else begin
                     state_d   = StTrap;
                     illegal_d = 1'b1;
                  end
               end
               default: begin
                  state_d   = StTrap;
                  illegal_d = 1'b1;
               end
            endcase
         end
         StMemAddr: state_d = is_store_q ? StMemWrite : StMemRead;
         StMemRead, StMemWrite: begin
            if (bus.mem_ready) begin
               state_d = (state_q == StMemRead) ? StMemWb : StFetch;
            end else if (timeout) begin
               state_d   = StTrap;
               bus_err_d = 1'b1;
            end
         end
         StExecR:  state_d = StRWb;
         StExecI:  state_d = StIWb;
         StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
         StTrap:   state_d = StTrap;
         default:  state_d = StFetch;
      endcase
   end

   always_comb begin
      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if (waiting && !bus.mem_ready) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.ir_write      = 1'b0;
      bus.reg_write     = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.pc_source     = 2'b00;
      bus.alu_ctrl      = '0;
      bus.retire        = 1'b0;
      bus.illegal       = 1'b0;
      bus.bus_err       = 1'b0;
      bus.state_out     = 4'd0;
      // Reset forces every output low, including Mealy enables.
      if (rst_n) begin
         bus.state_out = state_q;
         bus.illegal   = illegal_q;
         bus.bus_err   = bus_err_q;
         bus.alu_ctrl  = ALU_CTRL_W'(AluAdd);
         case (state_q)
            StFetch: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            StDecode:  bus.alu_src_b = 2'b11;
            StMemAddr, StExecI: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
            end
            StMemRead: begin
               bus.mem_read = 1'b1;
               bus.i_or_d   = 1'b1;
            end
            StMemWb: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
               bus.retire     = 1'b1;
            end
            StMemWrite: begin
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
               bus.retire    = bus.mem_ready;
            end
            StExecR: begin
               bus.alu_src_a = 1'b1;
               bus.alu_ctrl  = ALU_CTRL_W'(r_alu);
            end
            StRWb: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = 1'b1;
               bus.retire    = 1'b1;
            end
            StIWb: begin
               bus.reg_write = 1'b1;
               bus.retire    = 1'b1;
            end
            StBranch: begin
               bus.alu_src_a     = 1'b1;
               bus.alu_ctrl      = ALU_CTRL_W'(AluSub);
               bus.pc_write_cond = 1'b1;
               bus.pc_source     = 2'b01;
               bus.retire        = 1'b1;
            end
            StJump: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b10;
               bus.retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (ALU_CTRL_W=5, MEM_TIMEOUT=4): each driven cycle
// queues its expected outputs; a negedge monitor pops and compares.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;

   typedef struct {
      logic [25:0] v;
      string       tag;
   } exp_t;

   exp_t sb_q[$];

   multicycle_control_if #(.ALU_CTRL_W(5)) bus ();

   multicycle_control #(
      .ALU_CTRL_W (5),
      .MEM_TIMEOUT(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference output table, one row per state as listed for the control unit.
   function automatic logic [25:0] expv(input logic rstn, input int st, input logic rdy,
                                        input logic [4:0] alu_r, input logic ill,
                                        input logic berr);
      logic       pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, ret;
      logic [1:0] asb, pcs;
      logic [4:0] alu;
      {pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, ret} = '0;
      asb = 2'b00;
      pcs = 2'b00;
      alu = 5'd1;
      if (!rstn) return '0;
      case (st)
         0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
         1:  asb = 2'b11;
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; ret = 1; end
         5:  begin mw = 1; iod = 1; ret = rdy; end
         6:  begin asa = 1; alu = alu_r; end
         7:  begin rw = 1; rd = 1; ret = 1; end
         8:  begin asa = 1; asb = 2'b10; end
         9:  begin rw = 1; ret = 1; end
         10: begin asa = 1; alu = 5'd2; pwc = 1; pcs = 2'b01; ret = 1; end
         11: begin pw = 1; pcs = 2'b10; ret = 1; end
         default: ;
      endcase
      return {4'(st), pw, pwc, irw, rw, mr, mw, iod, m2r, rd, asa, asb, pcs, alu, ret, ill, berr};
   endfunction

   task automatic step(input logic rstn, input logic [5:0] o, input logic [5:0] f,
                       input logic rdy, input int st, input logic [4:0] alu_r,
                       input logic ill, input logic berr, input string tag);
      exp_t e;
      rst_n         = rstn;
      bus.op        = o;
      bus.funct     = f;
      bus.mem_ready = rdy;
      e.v   = expv(rstn, st, rdy, alu_r, ill, berr);
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic rtype(input logic [5:0] f, input logic [4:0] alu_r, input string tag);
      step(1, 6'h00, f, 1, 0, 0, 0, 0, {tag, "_fetch"});
      step(1, 6'h00, f, 1, 1, 0, 0, 0, {tag, "_decode"});
      step(1, 6'h00, f, 1, 6, alu_r, 0, 0, {tag, "_exec"});
      step(1, 6'h00, f, 1, 7, 0, 0, 0, {tag, "_wb"});
   endtask

   always @(negedge clk) begin
      logic [25:0] act;
      exp_t        e;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = {bus.state_out, bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.i_or_d, bus.mem_to_reg, bus.reg_dst,
                bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.alu_ctrl, bus.retire,
                bus.illegal, bus.bus_err};
         n_cmp++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (state %0d/%0d)", e.tag, act, e.v,
                     act[25:22], e.v[25:22]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.op        = '0;
      bus.funct     = '0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      step(0, 6'h00, 6'h00, 1, 0, 0, 0, 0, "reset0");
      step(0, 6'h00, 6'h00, 0, 0, 0, 0, 0, "reset1");

      rtype(6'b100000, 5'd1, "add");
      rtype(6'b100010, 5'd2, "sub");
      rtype(6'b100100, 5'd3, "and");
      rtype(6'b100101, 5'd4, "or");
      rtype(6'b101010, 5'd5, "slt");

      step(1, 6'b001000, 0, 1, 0, 0, 0, 0, "addi_fetch");
      step(1, 6'b001000, 0, 1, 1, 0, 0, 0, "addi_decode");
      step(1, 6'b001000, 0, 1, 8, 0, 0, 0, "addi_exec");
      step(1, 6'b001000, 0, 1, 9, 0, 0, 0, "addi_wb");

      step(1, 6'b100011, 0, 1, 0, 0, 0, 0, "lw_fetch");
      step(1, 6'b100011, 0, 1, 1, 0, 0, 0, "lw_decode");
      step(1, 6'b100011, 0, 1, 2, 0, 0, 0, "lw_addr");
      step(1, 6'b100011, 0, 0, 3, 0, 0, 0, "lw_rd_wait1");
      step(1, 6'b100011, 0, 0, 3, 0, 0, 0, "lw_rd_wait2");
      step(1, 6'b100011, 0, 0, 3, 0, 0, 0, "lw_rd_wait3");
      step(1, 6'b100011, 0, 1, 3, 0, 0, 0, "lw_rd_done");
      step(1, 6'b100011, 0, 1, 4, 0, 0, 0, "lw_wb");

      step(1, 6'b101011, 0, 1, 0, 0, 0, 0, "sw_fetch");
      step(1, 6'b101011, 0, 1, 1, 0, 0, 0, "sw_decode");
      step(1, 6'b101011, 0, 1, 2, 0, 0, 0, "sw_addr");
      step(1, 6'b101011, 0, 0, 5, 0, 0, 0, "sw_wr_wait");
      step(1, 6'b101011, 0, 1, 5, 0, 0, 0, "sw_wr_done");

      step(1, 6'b000100, 0, 1, 0, 0, 0, 0, "beq_fetch");
      step(1, 6'b000100, 0, 1, 1, 0, 0, 0, "beq_decode");
      step(1, 6'b000100, 0, 1, 10, 0, 0, 0, "beq_branch");
      step(1, 6'b000010, 0, 1, 0, 0, 0, 0, "j_fetch");
      step(1, 6'b000010, 0, 1, 1, 0, 0, 0, "j_decode");
      step(1, 6'b000010, 0, 1, 11, 0, 0, 0, "j_jump");

      // Ready on the last allowed FETCH cycle must win over the timeout.
      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "fw_wait1");
      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "fw_wait2");
      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "fw_wait3");
      step(1, 6'b000010, 0, 1, 0, 0, 0, 0, "fw_ready4");
      step(1, 6'b000010, 0, 1, 1, 0, 0, 0, "fw_decode");
      step(1, 6'b000010, 0, 1, 11, 0, 0, 0, "fw_jump");

      step(1, 6'b111111, 0, 1, 0, 0, 0, 0, "ilop_fetch");
      step(1, 6'b111111, 0, 1, 1, 0, 0, 0, "ilop_decode");
      step(1, 6'b111111, 0, 1, 12, 0, 1, 0, "ilop_trap1");
      step(1, 6'b000000, 6'b100000, 1, 12, 0, 1, 0, "ilop_trap2");
      step(0, 6'b000000, 0, 1, 0, 0, 0, 0, "ilop_reset");

      step(1, 6'b000000, 6'b000001, 1, 0, 0, 0, 0, "ilfn_fetch");
      step(1, 6'b000000, 6'b000001, 1, 1, 0, 0, 0, "ilfn_decode");
      step(1, 6'b000000, 6'b000001, 1, 12, 0, 1, 0, "ilfn_trap1");
      step(1, 6'b000000, 6'b000001, 0, 12, 0, 1, 0, "ilfn_trap2");
      step(0, 6'b000000, 0, 0, 0, 0, 0, 0, "ilfn_reset");

      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "to_wait1");
      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "to_wait2");
      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "to_wait3");
      step(1, 6'b000010, 0, 0, 0, 0, 0, 0, "to_wait4");
      step(1, 6'b000010, 0, 1, 12, 0, 0, 1, "to_trap1");
      step(1, 6'b000010, 0, 1, 12, 0, 0, 1, "to_trap2");
      step(0, 6'b000010, 0, 1, 0, 0, 0, 0, "to_reset");

      // op changes after DECODE must not redirect the store; reset then aborts MEM_WRITE.
      step(1, 6'b101011, 0, 1, 0, 0, 0, 0, "swr_fetch");
      step(1, 6'b101011, 0, 1, 1, 0, 0, 0, "swr_decode");
      step(1, 6'b100011, 0, 1, 2, 0, 0, 0, "swr_addr");
      step(1, 6'b100011, 0, 0, 5, 0, 0, 0, "swr_wr_wait");
      step(0, 6'b100011, 0, 0, 5, 0, 0, 0, "swr_reset");
      step(1, 6'b000010, 0, 1, 0, 0, 0, 0, "swr_fetch2");
      step(1, 6'b000010, 0, 1, 1, 0, 0, 0, "swr_decode2");
      step(1, 6'b000010, 0, 1, 11, 0, 0, 0, "swr_jump2");

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit: a Moore/Mealy state machine replacing the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back over several clocks, and adds the AND/OR/SLT R-types. It also adds a memory ready handshake with a timeout, and a sticky trap on illegal instructions or bus timeout. It sits between the instruction register/datapath and the shared instruction/data memory port.

## Interface
- ALU_CTRL_W, 3, width of alu_ctrl (≥3); codes zero-extended.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready per access; 0 disables the timeout.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- op  in  6  instruction opcode, valid from DECODE onward (from IR).
- funct  in  6  R-type function field.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1  datapath enables.
- i_or_d, mem_to_reg, reg_dst, alu_src_a  out  1  datapath mux selects.
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- pc_source  out  2  00 ALU result, 01 ALU out reg, 10 jump target.
- alu_ctrl  out  ALU_CTRL_W  ALU operation code.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- illegal, bus_err  out  1  sticky trap causes.
- state_out  out  4  current state encoding.

## Operation
- ALU codes: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT.
- Opcodes: 000000 R-type; 001000 addi; 100011 lw; 101011 sw; 000100 beq; 000010 j.
- R-type funct values: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- Any other op, or any other funct under op 000000, is illegal.
- Unlisted outputs in each state are 0. In every state except EXEC_R and BRANCH, alu_ctrl is ADD.

States and encodings:
- FETCH 0: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, pc_source=00. When mem_ready=1: ir_write=1 and pc_write=1 that cycle, next state DECODE. Otherwise stay.
- DECODE 1: alu_src_a=0, alu_src_b=11. Next state by opcode:
  - lw/sw → MEM_ADDR
  - R-type with legal funct → EXEC_R
  - addi → EXEC_I
  - beq → BRANCH
  - j → JUMP
  - otherwise → TRAP, illegal set.
- MEM_ADDR 2: alu_src_a=1, alu_src_b=10. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ 3: mem_read=1, i_or_d=1. Wait on mem_ready, then MEM_WB.
- MEM_WB 4: reg_write=1, mem_to_reg=1, reg_dst=0, retire=1. Next state FETCH.
- MEM_WRITE 5: mem_write=1, i_or_d=1. mem_write is held until the mem_ready cycle. retire=1 in that cycle, next state FETCH.
- EXEC_R 6: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Next state R_WB.
- R_WB 7: reg_write=1, reg_dst=1, retire=1. Next state FETCH.
- EXEC_I 8: alu_src_a=1, alu_src_b=10. Next state I_WB.
- I_WB 9: reg_write=1, reg_dst=0, retire=1. Next state FETCH.
- BRANCH 10: alu_src_a=1, alu_src_b=00, alu_ctrl=SUB, pc_write_cond=1, pc_source=01, retire=1. Next state FETCH.
- JUMP 11: pc_write=1, pc_source=10, retire=1. Next state FETCH.
- TRAP 12: all enables 0. Held until reset; the illegal/bus_err flags stay set.

Wait timeout:
- Wait states are FETCH, MEM_READ and MEM_WRITE.
- wait_cnt clears on every state change and increments each wait cycle with mem_ready=0.
- If MEM_TIMEOUT>0, wait_cnt==MEM_TIMEOUT-1 and mem_ready=0: next state TRAP, bus_err set.
- mem_ready arriving on that same cycle wins; no trap.

## Timing
- Reset: while rst_n=0, every output is forced to 0 combinationally. At the clock edge: state←FETCH, wait_cnt←0, illegal←0, bus_err←0.
- Reset mid-instruction aborts it; no write enable is asserted during reset cycles.
- ir_write, pc_write (FETCH) and mem_write completion are Mealy outputs, gated same-cycle by mem_ready. All other outputs are Moore, decoded from the state register.
- Latency with mem_ready tied high:
  - beq, j: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Each mem_ready-low cycle adds one cycle.
- op and funct are sampled only in DECODE and EXEC_R; changes elsewhere are ignored.

## Test plan
- R-type add (op 000000, funct 100000), mem_ready=1 → states 0,1,6,7,0; alu_ctrl=001 in EXEC_R; reg_write=1, reg_dst=1 in R_WB; retire pulses once on cycle 4.
- lw with mem_ready low for 3 cycles in MEM_READ → MEM_READ lasts 4 cycles; then MEM_WB with mem_to_reg=1, reg_write=1; total 8 cycles.
- beq then j, back-to-back → BRANCH asserts pc_write_cond=1, pc_source=01, alu_ctrl=010; JUMP asserts pc_write=1, pc_source=10; each takes 3 cycles.
- Illegal op 111111, and separately funct 000001 under op 0 → TRAP (state 12), illegal=1, all enables 0. Remains in TRAP until rst_n=0 for one edge, then back to FETCH with illegal=0.
- MEM_TIMEOUT=4, mem_ready held low in FETCH → TRAP after 4 FETCH cycles, bus_err=1. Repeat with mem_ready=1 on the 4th cycle → DECODE, no trap.
- rst_n=0 asserted during MEM_WRITE → mem_write drops to 0 that cycle; state 0 after the edge; ALU_CTRL_W=5 run shows alu_ctrl upper bits 0.
